// File: rtl/pll_rst_ctrl.sv
// PLL reset/lock supervisor: pulses pll_reset, qualifies lock, releases sys_rst_n/ready.
// Latency: pll_lock reaches the state machine 2 cycles late (synchronizer); outputs are registered off next-state.
// Backpressure: none; soft_req preempts every transition and holds the block in RST.
module pll_rst_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             soft_req,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [CNT_W-1:0] timeout_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lock_meta, lock_s;
  logic          timeout_inc, loss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 1'b1;
    timeout_inc = 1'b0;
    loss_inc    = 1'b0;
    if (soft_req) begin
      state_nx = ST_RST;
    end else begin
      case (state)
        ST_RST: begin
          if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nx = ST_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            state_nx    = ST_RST;
            timeout_inc = 1'b1;
          end
        end
        ST_STABLE: begin
          // A lock dropout here restarts the whole timeout window without counting.
          if (!lock_s) state_nx = ST_WAIT_LOCK;
          else if (cnt == STABLE_LAST) state_nx = ST_READY;
        end
        ST_READY: begin
          cnt_nx = cnt;
          if (!lock_s) begin
            state_nx = ST_RST;
            loss_inc = 1'b1;
          end
        end
        default: state_nx = ST_RST;
      endcase
    end
    // soft_req in RST does not change state but must still restart the count.
    if (soft_req || (state_nx != state)) cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pll_reset <= (state_nx == ST_RST);
      sys_rst_n <= (state_nx == ST_READY);
      ready     <= (state_nx == ST_READY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
      loss_cnt    <= '0;
    end else begin
      if (timeout_inc && (timeout_cnt != {CNT_W{1'b1}})) timeout_cnt <= timeout_cnt + 1'b1;
      if (loss_inc && (loss_cnt != {CNT_W{1'b1}}))       loss_cnt    <= loss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl: stimulus queues the expected output changes with their cycle,
// a negedge monitor pops one entry each time any output changes and compares cycle and value.
module tb_pll_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       soft_req;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] timeout_cnt;
  logic [1:0] loss_cnt;

  pll_rst_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (10),
    .STABLE_CYCLES(8),
    .CNT_W        (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .soft_req   (soft_req),
    .pll_reset  (pll_reset),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .timeout_cnt(timeout_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int       cyc;
    logic [6:0] v;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [6:0] outs();
    return {pll_reset, sys_rst_n, ready, timeout_cnt, loss_cnt};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic pr, input logic srn, input logic rdy,
                      input logic [1:0] tc, input logic [1:0] lc);
    exp_t e;
    e.cyc = c;
    e.v   = {pr, srn, rdy, tc, lc};
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, int'(pll_reset), 1);
    chk({tag, "_sys_rst_n"}, int'(sys_rst_n), 0);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_timeout_cnt"}, int'(timeout_cnt), 0);
    chk({tag, "_loss_cnt"}, int'(loss_cnt), 0);
  endtask

  // Monitor: every output change must match the next queued expectation.
  initial begin
    logic [6:0] prev, cur;
    exp_t e;
    wait (mon_en);
    @(negedge clk);
    prev = outs();
    forever begin
      @(negedge clk);
      cur = outs();
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change: got %b with no change expected (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("change_cycle", cyc, e.cyc);
          chk("change_value", int'(cur), int'(e.v));
        end
      end
      prev = cur;
    end
  end

  initial begin
    int b;
    rst_n    = 1'b0;
    pll_lock = 1'b1;
    soft_req = 1'b0;
    wait_neg(3);
    chk_reset_vals("reset");

    // Power-up with lock tied high: 4 cycles of pll_reset, ready 9 cycles later.
    b = cyc;
    push(b + 4,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    push(b + 13, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    wait_neg(15);

    // One-cycle lock dropout in READY: 3 edges to react, loss counted, relock.
    b = cyc;
    push(b + 3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    push(b + 7,  1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    push(b + 16, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1);
    pll_lock = 1'b0;
    wait_neg(1);
    pll_lock = 1'b1;
    wait_neg(18);

    // soft_req in READY, then a 3-cycle glitch while STABLE sits at cnt=5.
    b = cyc;
    push(b + 1,  1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    push(b + 5,  1'b0, 1'b0, 1'b0, 2'd0, 2'd1);
    push(b + 25, 1'b0, 1'b1, 1'b1, 2'd0, 2'd1);
    soft_req = 1'b1;
    wait_neg(1);
    soft_req = 1'b0;
    wait_neg(10);
    pll_lock = 1'b0;
    wait_neg(3);
    pll_lock = 1'b1;
    wait_neg(14);

    // Lock lost for good: loss, soft_req on the first timeout edge, then saturating retries.
    b = cyc;
    push(b + 3,  1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
    push(b + 7,  1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    push(b + 17, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2);
    push(b + 21, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2);
    push(b + 31, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2);
    push(b + 35, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2);
    push(b + 45, 1'b1, 1'b0, 1'b0, 2'd2, 2'd2);
    push(b + 49, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2);
    push(b + 59, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2);
    push(b + 63, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2);
    push(b + 73, 1'b1, 1'b0, 1'b0, 2'd3, 2'd2);
    push(b + 77, 1'b0, 1'b0, 1'b0, 2'd3, 2'd2);
    pll_lock = 1'b0;
    wait_neg(16);
    soft_req = 1'b1;
    wait_neg(1);
    soft_req = 1'b0;
    wait_neg(61);

    // Relock into STABLE, then assert rst_n between clock edges.
    b = cyc;
    pll_lock = 1'b1;
    wait_neg(6);
    push(b + 7, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    wait_neg(3);

    b = cyc;
    push(b + 4,  1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    push(b + 13, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    rst_n = 1'b1;
    wait_neg(2);
    chk("post_release_timeout_cnt", int'(timeout_cnt), 0);
    chk("post_release_loss_cnt", int'(loss_cnt), 0);
    wait_neg(16);

    chk("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
